// File: rtl/ext_mem_pkg.sv
// Shared types and defaults for the external memory bus arbiter.
// Holds the sequencer state encoding, requester ids and default bus widths.
package ext_mem_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int TIMER_W     = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner selection with a registered last-grant pointer.
// The winner is combinational; last_grant advances only when a grant is taken.
module rr_arb2
  import ext_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic valid,
  output logic winner
);

  logic last_grant;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid  = req0 | req1;
    winner = REQ_CPU;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = REQ_DMA;
    end
  end

  // Reset points at the DMA side so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_DMA;
    end else if (update) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Shares one external memory bus between the CPU (M0) and DMA engine (M1).
// One transaction at a time: IDLE -> ACCESS (wait ready or timeout) -> RELEASE.
module ext_mem_arbiter
  import ext_mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_cs,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_e             state;
  logic [TIMER_W-1:0] timer;
  logic               cur_we;
  logic               arb_valid;
  logic               arb_winner;
  logic               arb_take;
  logic [DATA_W-1:0]  done_rdata;

  assign arb_take   = (state == IDLE) && arb_valid;
  // Timeout without ready returns all ones to the reader.
  assign done_rdata = mem_ready ? mem_rdata : {DATA_W{1'b1}};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0   (m0_req),
    .req1   (m1_req),
    .update (arb_take),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      cur_we    <= 1'b0;
      mem_cs    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= REQ_CPU;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; acks default low so each is a single-cycle pulse.
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state    <= ACCESS;
            timer    <= '0;
            busy     <= 1'b1;
            mem_cs   <= 1'b1;
            grant_id <= arb_winner;
            if (arb_winner == REQ_DMA) begin
              mem_addr  <= m1_addr;
              mem_wdata <= m1_wdata;
              cur_we    <= m1_we;
              mem_read  <= ~m1_we;
              mem_write <= m1_we;
            end else begin
              mem_addr  <= m0_addr;
              mem_wdata <= m0_wdata;
              cur_we    <= m0_we;
              mem_read  <= ~m0_we;
              mem_write <= m0_we;
            end
          end
        end
        ACCESS: begin
          // Ready takes priority over a coincident timeout.
          if (mem_ready || (timer == TIMER_LAST)) begin
            state     <= RELEASE;
            mem_cs    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (grant_id == REQ_DMA) begin
              m1_ack <= 1'b1;
              m1_err <= ~mem_ready;
              if (!cur_we) m1_rdata <= done_rdata;
            end else begin
              m0_ack <= 1'b1;
              m0_err <= ~mem_ready;
              if (!cur_we) m0_rdata <= done_rdata;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RELEASE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          m0_err <= 1'b0;
          m1_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Self-checking bench for ext_mem_arbiter: directed scenarios plus randomized
// two-master traffic checked against a round-robin and shadow-memory model.
module tb_ext_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_read, mem_write, mem_cs, mem_ready;
  logic          busy, grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  ext_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_cs(mem_cs),
    .mem_ready(mem_ready), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Memory device: answers after wait_cur extra cycles of cs; address 0x0400 never answers.
  logic [DW-1:0] mem_arr [0:65535];
  logic [DW-1:0] shadow [0:63];
  logic ready_r = 1'b0;
  logic ready_kick = 1'b0;
  int   wcnt = 0;
  int   wait_cur = 0;
  int   max_wait = 0;
  assign mem_ready = ready_r | ready_kick;

  always @(posedge clk) begin
    if (rst) begin
      ready_r <= 1'b0;
      wcnt    <= 0;
    end else if (mem_cs && !ready_r && mem_addr != 16'h0400) begin
      if (wcnt >= wait_cur) begin
        ready_r <= 1'b1;
        wcnt    <= 0;
        if (mem_write) mem_arr[mem_addr] = mem_wdata;
        else mem_rdata <= mem_arr[mem_addr];
        wait_cur <= int'($urandom_range(0, max_wait));
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      ready_r <= 1'b0;
      if (!mem_cs) wcnt <= 0;
    end
  end

  // Arbitration model: at each new select, the winner follows the round-robin rule
  // applied to the requests present at that edge.
  logic p_r0 = 1'b0, p_r1 = 1'b0, p_cs = 1'b0, p_rst = 1'b1, mdl_last = 1'b1, exp_id;
  logic [AW-1:0] p_a0 = '0, p_a1 = '0;
  always @(negedge clk) begin
    if (p_rst) begin
      mdl_last = 1'b1;
    end else if (mem_cs && !p_cs) begin
      exp_id = (p_r0 && p_r1) ? ~mdl_last : p_r1;
      n_cmp++;
      if (!(p_r0 || p_r1) || grant_id !== exp_id || mem_addr !== (exp_id ? p_a1 : p_a0)) begin
        n_bad++;
        $display("FAIL grant_model: got id=%0d addr=%h, wanted id=%0d addr=%h (req0=%0d req1=%0d)",
                 grant_id, mem_addr, exp_id, exp_id ? p_a1 : p_a0, p_r0, p_r1);
      end
      mdl_last = exp_id;
    end
    if (m0_ack || m1_ack) begin
      n_cmp++;
      if (m0_ack && m1_ack) begin
        n_bad++;
        $display("FAIL dual_ack: got both acks high, wanted one at %0t", $time);
      end
    end
    p_r0 = m0_req; p_r1 = m1_req; p_a0 = m0_addr; p_a1 = m1_addr;
    p_cs = mem_cs; p_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({mem_cs, mem_read, mem_write, m0_ack, m1_ack, m0_err, m1_err, busy, grant_id} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, wanted 000000000",
               {mem_cs, mem_read, mem_write, m0_ack, m1_ack, m0_err, m1_err, busy, grant_id});
    end
    n_cmp++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: got addr=%h wdata=%h, wanted 0000/00", mem_addr, mem_wdata);
    end
    n_cmp++;
    if (m0_rdata !== '0 || m1_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_rdata: got %h/%h, wanted 00/00", m0_rdata, m1_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_m0_read();
    int  cyc = 1;
    bit  got = 0, read_seen = 0, read_bad = 0;
    mem_arr[16'h0000] = 8'h64;
    m0_we = 1'b0; m0_addr = 16'h0000; m0_req = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      tick(); cyc++;
      if (mem_read) begin
        read_seen = 1;
        if (!(mem_cs && busy && !m0_ack)) read_bad = 1;
      end
      if (m0_ack) got = 1;
    end
    n_cmp++;
    if (!got || cyc != 4) begin
      n_bad++;
      $display("FAIL m0_read_latency: got ack=%0d at cycle %0d, wanted ack at cycle 4", got, cyc);
    end
    n_cmp++;
    if (m0_rdata !== 8'h64 || m0_err !== 1'b0) begin
      n_bad++;
      $display("FAIL m0_read_data: got rdata=%h err=%0d, wanted 64/0", m0_rdata, m0_err);
    end
    n_cmp++;
    if (!read_seen || read_bad) begin
      n_bad++;
      $display("FAIL m0_read_strobe: got seen=%0d outside_access=%0d, wanted 1/0", read_seen, read_bad);
    end
    m0_req = 1'b0;
    tick();
    n_cmp++;
    if (m0_ack !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL m0_ack_pulse: got ack=%0d busy=%0d after release, wanted 0/0", m0_ack, busy);
    end
  endtask

  task automatic test_m1_write();
    bit got = 0, unstable = 0, m0_seen = 0;
    int cs_cycles = 0;
    m1_we = 1'b1; m1_addr = 16'h0123; m1_wdata = 8'hA5; m1_req = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (mem_cs) begin
        cs_cycles++;
        if (mem_addr !== 16'h0123 || mem_wdata !== 8'hA5 || !mem_write || mem_read) unstable = 1;
      end
      if (m0_ack) m0_seen = 1;
      if (m1_ack) got = 1;
    end
    n_cmp++;
    if (!got || unstable || cs_cycles == 0) begin
      n_bad++;
      $display("FAIL m1_write_bus: got ack=%0d unstable=%0d cs_cycles=%0d, wanted 1/0/>0", got, unstable, cs_cycles);
    end
    n_cmp++;
    if (mem_arr[16'h0123] !== 8'hA5) begin
      n_bad++;
      $display("FAIL m1_write_mem: got %h, wanted a5", mem_arr[16'h0123]);
    end
    n_cmp++;
    if (m0_seen || m1_err !== 1'b0 || grant_id !== 1'b1) begin
      n_bad++;
      $display("FAIL m1_write_ack: got m0_ack_seen=%0d err=%0d grant=%0d, wanted 0/0/1", m0_seen, m1_err, grant_id);
    end
    m1_req = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic order [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    int   ngr = 0, nack = 0, idle_run = 0;
    bit   gap_bad = 0, prev_cs = 0;
    apply_reset();
    m0_we = 1'b0; m0_addr = 16'h0001; m1_we = 1'b0; m1_addr = 16'h0002;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 100 && nack < 4; i++) begin
      tick();
      if (mem_cs && !prev_cs) begin
        if (ngr > 0 && idle_run < 1) gap_bad = 1;
        if (ngr < 4) order[ngr] = grant_id;
        ngr++;
      end
      idle_run = mem_cs ? 0 : idle_run + 1;
      prev_cs = mem_cs;
      if (m0_ack || m1_ack) nack++;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (order[k] !== exp_order[k]) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got grant %0d, wanted %0d", k, order[k], exp_order[k]);
      end
    end
    n_cmp++;
    if (nack != 4 || gap_bad) begin
      n_bad++;
      $display("FAIL rr_gap: got acks=%0d gap_violation=%0d, wanted 4/0", nack, gap_bad);
    end
    tick(); tick();
  endtask

  task automatic test_timeout();
    bit got = 0;
    int cs_cnt = 0;
    m0_we = 1'b0; m0_addr = 16'h0400; m0_req = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (mem_cs) cs_cnt++;
      if (m0_ack) got = 1;
    end
    n_cmp++;
    if (!got || cs_cnt != TO) begin
      n_bad++;
      $display("FAIL timeout_len: got ack=%0d cs_cycles=%0d, wanted 1/%0d", got, cs_cnt, TO);
    end
    n_cmp++;
    if (m0_err !== 1'b1 || m0_rdata !== 8'hFF) begin
      n_bad++;
      $display("FAIL timeout_resp: got err=%0d rdata=%h, wanted 1/ff", m0_err, m0_rdata);
    end
    m0_req = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || mem_cs !== 1'b0 || m0_err !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_idle: got busy=%0d cs=%0d err=%0d, wanted 0/0/0", busy, mem_cs, m0_err);
    end
  endtask

  task automatic test_reset_mid_access();
    bit got = 0, stray = 0;
    m1_we = 1'b0; m1_addr = 16'h0010; m1_req = 1'b1;
    for (int i = 0; i < 20 && !mem_cs; i++) tick();
    tick();
    rst = 1'b1; m1_req = 1'b0;
    tick();
    n_cmp++;
    if ({mem_cs, mem_read, busy, m1_ack} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_abort: got cs/read/busy/ack=%b, wanted 0000", {mem_cs, mem_read, busy, m1_ack});
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m1_ack || m0_ack) stray = 1;
    end
    n_cmp++;
    if (stray) begin
      n_bad++;
      $display("FAIL reset_no_ack: got an ack after abort, wanted none");
    end
    m0_we = 1'b0; m0_addr = 16'h0005; m1_addr = 16'h0006;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 20 && !mem_cs; i++) tick();
    n_cmp++;
    if (mem_cs !== 1'b1 || grant_id !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_first_grant: got cs=%0d grant=%0d, wanted 1/0", mem_cs, grant_id);
    end
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (m0_ack) got = 1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_ready_idle();
    bit bad = 0;
    ready_kick = 1'b1;
    tick();
    ready_kick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m0_ack || m1_ack || busy || mem_cs) bad = 1;
      tick();
    end
    n_cmp++;
    if (bad || m0_ack || m1_ack || busy) begin
      n_bad++;
      $display("FAIL ready_idle: got ack/busy activity on stray ready, wanted none");
    end
  endtask

  task automatic run_master(input int id, input int nops);
    int            gap;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rd;
    logic          ack, err;
    bit            got;
    for (int k = 0; k < nops; k++) begin
      gap = int'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      a   = AW'($urandom_range(0, 63));
      d   = DW'($urandom);
      got = 0;
      for (int g = 0; g < gap; g++) tick();
      if (id == 0) begin m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1'b1; end
      else begin m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1'b1; end
      for (int c = 0; c < 64 && !got; c++) begin
        tick();
        ack = (id == 0) ? m0_ack : m1_ack;
        if (ack) got = 1;
      end
      err = (id == 0) ? m0_err : m1_err;
      rd  = (id == 0) ? m0_rdata : m1_rdata;
      n_cmp++;
      if (!got || err !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_ack m%0d op%0d: got ack=%0d err=%0d, wanted 1/0", id, k, got, err);
      end else if (we) begin
        shadow[a[5:0]] = d;
      end else begin
        n_cmp++;
        if (rd !== shadow[a[5:0]]) begin
          n_bad++;
          $display("FAIL rand_read m%0d addr=%h: got %h, wanted %h", id, a, rd, shadow[a[5:0]]);
        end
      end
      if (id == 0) m0_req = 1'b0;
      else m1_req = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] v;
    max_wait = 3;
    for (int i = 0; i < 64; i++) begin
      v = DW'($urandom);
      mem_arr[i] = v;
      shadow[i]  = v;
    end
    fork
      run_master(0, 12);
      run_master(1, 12);
    join
    tick(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_m0_read();
    test_m1_write();
    test_round_robin();
    test_timeout();
    test_reset_mid_access();
    test_ready_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_mem_arbiter.md
Name: ext_mem_arbiter

Overview:
- Sequences and shares the single external memory bus (16-bit address, 8-bit data, read/write/chip-select strobes, ready handshake) between two requesters: M0 = CPU core, M1 = DMA/UART buffer engine.
- Round-robin arbitration, one transaction at a time, bounded wait on mem_ready with timeout/error.
- Sits in the system top between the internal masters and the external bus pins; the top owns the tristate on the data pins.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- TIMEOUT_CYCLES, 16, ACCESS cycles allowed without mem_ready before error; legal range 2..255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  M0 request; held high until m0_ack
- m0_we  in  1  M0 1=write, 0=read
- m0_addr  in  ADDR_W  M0 address
- m0_wdata  in  DATA_W  M0 write data
- m0_rdata  out  DATA_W  M0 read data, valid with m0_ack
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  timeout flag, qualified by m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: identical for M1
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_rdata  in  DATA_W  bus read data
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_cs  out  1  chip select
- mem_ready  in  1  memory completion
- busy  out  1  high in ACCESS and RELEASE
- grant_id  out  1  requester owning the current/last transaction

Behaviour:
- All outputs registered. Reset: state IDLE; mem_cs/mem_read/mem_write/acks/errs/busy = 0; mem_addr, mem_wdata, m0_rdata, m1_rdata = 0; grant_id = 0; last_grant = 1, so M0 wins the first tie.
- States: IDLE, ACCESS, RELEASE.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both reqs: grant the one != last_grant.
  - On grant: latch addr/we/wdata, set grant_id and last_grant, go ACCESS. mem_cs and (mem_read = !we, mem_write = we) go high on the same edge.
- ACCESS:
  - Strobes, addr and wdata are held stable. Timer counts from 0.
  - mem_ready=1: capture mem_rdata into the granted requester's rdata (reads only; rdata holds its value on writes), drop all strobes, pulse that requester's ack for exactly one cycle (the RELEASE cycle), err=0, go RELEASE.
  - Timer reaches TIMEOUT_CYCLES-1 with no ready: drop strobes, ack with err=1, rdata = all ones for reads, go RELEASE.
  - mem_ready and timeout on the same cycle: ready wins, no error.
- RELEASE: exactly one idle bus cycle (cs=0) so the memory sees deasserted select, then IDLE. New grant earliest on the following edge, so back-to-back transactions are separated by ≥1 idle cycle.
- mem_ready in IDLE or RELEASE is ignored.
- Latency: req sampled at edge N gives cs high after N. If ready is first seen at edge R, ack is high during cycle R..R+1. With a memory that registers ready one cycle after seeing cs, a transaction is 4 cycles from req to ack.
- Request protocol:
  - A req dropped before grant is simply not served.
  - A req dropped after grant does not abort: the access completes and ack still pulses.
  - A requester's req still high in IDLE after its ack is treated as a new request.
- Never more than one ack per transaction. Never both acks in the same cycle.
- Reset mid-ACCESS: next edge returns to IDLE with all strobes and acks low. No ack for the aborted transaction. last_grant reset to 1.
- Timer width is 8 bits; it does not wrap within a transaction.

Decomposition:
- Shared package ext_mem_pkg: state enum (IDLE, ACCESS, RELEASE), requester id constants REQ_CPU=0 and REQ_DMA=1, default widths.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin winner selector plus registered last_grant. Everything else stays in ext_mem_arbiter.

Test Plan:
- M0 read, addr 0x0000, memory holds 0x64, ready one cycle after cs → m0_ack one cycle with m0_rdata=0x64, m0_err=0, 4 cycles req→ack, mem_read high only in ACCESS.
- M1 write, addr 0x0123, data 0xA5 → mem_write and cs high with addr 0x0123 and wdata 0xA5 stable until ready; memory[0x0123]=0xA5; m1_ack pulse; m0_ack stays 0.
- M0 and M1 both request from reset, held through 4 transactions → grant order M0, M1, M0, M1; cs low ≥1 cycle between transactions.
- M0 read to addr 0x0400, which never gets ready, TIMEOUT_CYCLES=16 → cs high exactly 16 cycles, then m0_ack=1, m0_err=1, m0_rdata=0xFF, then IDLE.
- rst asserted on the 2nd ACCESS cycle of an M1 read → next edge cs/read/busy=0, no m1_ack. After release, M0 and M1 requesting together → M0 granted first.
- mem_ready pulsed while IDLE with no req → no ack, state stays IDLE.
